rect_plot_arbiter: RTL and testbench

- Shares the single pixel-write port (CounterX/CounterY/color to the VGA framebuffer adapter, 320x240, 3-bit colour) between several rectangle drawers: paddle 1, paddle 2, ball, erase/clear.
- Each requester asks for one filled rectangle with a req/done handshake.
- The block arbitrates, latches the geometry, clips it to the screen and rasterises it at one pixel per accepted cycle.

---
 rtl/rect_plot_arbiter.sv | 179 +++++++++++++++++
 tb/tb_rect_plot_arbiter.sv | 376 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rect_plot_arbiter.sv
// rtl/rect_plot_arbiter.sv - round-robin arbiter rasterising clipped filled rectangles onto one pixel port
// Optional: define CLEAR_PRIORITY_EN to let requester 0 (clear/erase) take precedence in arbitration.
module rect_plot_arbiter #(
    parameter int NUM_REQ  = 4,
    parameter int XW       = 10,
    parameter int YW       = 9,
    parameter int SCREEN_W = 320,
    parameter int SCREEN_H = 240
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_REQ-1:0]    req,
    input  logic [NUM_REQ*XW-1:0] rect_x,
    input  logic [NUM_REQ*YW-1:0] rect_y,
    input  logic [NUM_REQ*XW-1:0] rect_w,
    input  logic [NUM_REQ*YW-1:0] rect_h,
    input  logic [NUM_REQ*3-1:0]  rect_color,
    output logic [NUM_REQ-1:0]    grant,
    output logic [NUM_REQ-1:0]    done,
    output logic                  busy,
    input  logic                  plot_ready,
    output logic                  plot,
    output logic [XW-1:0]         CounterX,
    output logic [YW-1:0]         CounterY,
    output logic [2:0]            color
);
    localparam int          IW    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [XW:0] SCR_W = SCREEN_W[XW:0];
    localparam logic [YW:0] SCR_H = SCREEN_H[YW:0];

    typedef enum logic [1:0] {IDLE, SETUP, DRAW, FINISH} state_t;
    state_t state, state_next;

    logic [IW-1:0] ptr, gidx, sel_idx, ptr_inc;
    logic          sel_found;
    int            cand;
    logic [XW-1:0] x0;
    logic [XW:0]   x_end, x_sum;
    logic [YW:0]   y_end, y_sum;
    logic [XW-1:0] g_x, g_w;
    logic [YW-1:0] g_y, g_h;
    logic [2:0]    g_color;
    logic          setup_empty, xfer, row_last, rect_last;
`ifdef CLEAR_PRIORITY_EN
    logic          last_zero;
`endif

    assign busy    = (state != IDLE);
    assign ptr_inc = (gidx == IW'(NUM_REQ - 1)) ? '0 : gidx + IW'(1);

    // Geometry of the granted requester, widened by one bit so the end never wraps.
    always_comb begin
        g_x         = rect_x[gidx*XW +: XW];
        g_w         = rect_w[gidx*XW +: XW];
        g_y         = rect_y[gidx*YW +: YW];
        g_h         = rect_h[gidx*YW +: YW];
        g_color     = rect_color[gidx*3 +: 3];
        x_sum       = {1'b0, g_x} + {1'b0, g_w};
        y_sum       = {1'b0, g_y} + {1'b0, g_h};
        setup_empty = (g_w == '0) || (g_h == '0) ||
                      ({1'b0, g_x} >= SCR_W) || ({1'b0, g_y} >= SCR_H);
        xfer        = plot && plot_ready;
        row_last    = ({1'b0, CounterX} + {{XW{1'b0}}, 1'b1}) == x_end;
        rect_last   = row_last && (({1'b0, CounterY} + {{YW{1'b0}}, 1'b1}) == y_end);
    end

    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        cand      = 0;
`ifdef CLEAR_PRIORITY_EN
        // Requester 0 wins unless it was served last; the pointer rotates over the others only.
        if (req[0] && !last_zero) begin
            sel_found = 1'b1;
        end else begin
            for (int k = 0; k < NUM_REQ; k++) begin
                cand = int'(ptr) + k;
                if (cand >= NUM_REQ) cand = cand - NUM_REQ;
                if (!sel_found && cand != 0 && req[cand]) begin
                    sel_found = 1'b1;
                    sel_idx   = IW'(cand);
                end
            end
            if (!sel_found && req[0]) sel_found = 1'b1;
        end
`else
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = int'(ptr) + k;
            if (cand >= NUM_REQ) cand = cand - NUM_REQ;
            if (!sel_found && req[cand]) begin
                sel_found = 1'b1;
                sel_idx   = IW'(cand);
            end
        end
`endif
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (sel_found) state_next = SETUP;
            SETUP:   state_next = setup_empty ? FINISH : DRAW;
            DRAW:    if (xfer && rect_last) state_next = FINISH;
            FINISH:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_next;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            grant    <= '0;
            done     <= '0;
            plot     <= 1'b0;
            CounterX <= '0;
            CounterY <= '0;
            color    <= '0;
            ptr      <= '0;
            gidx     <= '0;
            x0       <= '0;
            x_end    <= '0;
            y_end    <= '0;
`ifdef CLEAR_PRIORITY_EN
            last_zero <= 1'b0;
`endif
        end else begin
            done <= '0;
            case (state)
                IDLE: begin
                    if (sel_found) begin
                        grant <= NUM_REQ'(1) << sel_idx;
                        gidx  <= sel_idx;
                    end
                end
                SETUP: begin
                    x0    <= g_x;
                    x_end <= (x_sum > SCR_W) ? SCR_W : x_sum;
                    y_end <= (y_sum > SCR_H) ? SCR_H : y_sum;
                    if (setup_empty) begin
                        grant <= '0;
                        done  <= grant;
                    end else begin
                        CounterX <= g_x;
                        CounterY <= g_y;
                        color    <= g_color;
                        plot     <= 1'b1;
                    end
                end
                DRAW: begin
                    if (xfer) begin
                        if (rect_last) begin
                            plot  <= 1'b0;
                            grant <= '0;
                            done  <= grant;
                        end else if (row_last) begin
                            CounterX <= x0;
                            CounterY <= CounterY + YW'(1);
                        end else begin
                            CounterX <= CounterX + XW'(1);
                        end
                    end
                end
                FINISH: begin
`ifdef CLEAR_PRIORITY_EN
                    last_zero <= (gidx == '0);
                    if (gidx != '0) ptr <= ptr_inc;
`else
                    ptr <= ptr_inc;
`endif
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_rect_plot_arbiter.sv
// tb/tb_rect_plot_arbiter.sv - randomized self-checking bench for rect_plot_arbiter
`timescale 1ns/1ps
module tb_rect_plot_arbiter;
    localparam int N = 4, XW = 10, YW = 9, SW = 320, SH = 240;

    typedef logic [31:0] pix_q_t [$];

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req;
    logic [N*XW-1:0] rect_x, rect_w;
    logic [N*YW-1:0] rect_y, rect_h;
    logic [N*3-1:0]  rect_color;
    logic [N-1:0]    grant, done;
    logic            busy, plot_ready, plot;
    logic [XW-1:0]   CounterX;
    logic [YW-1:0]   CounterY;
    logic [2:0]      color;
    logic [31:0]     pix_now;

    rect_plot_arbiter #(.NUM_REQ(N), .XW(XW), .YW(YW), .SCREEN_W(SW), .SCREEN_H(SH)) dut (
        .clk(clk), .rst(rst), .req(req),
        .rect_x(rect_x), .rect_y(rect_y), .rect_w(rect_w), .rect_h(rect_h), .rect_color(rect_color),
        .grant(grant), .done(done), .busy(busy),
        .plot_ready(plot_ready), .plot(plot),
        .CounterX(CounterX), .CounterY(CounterY), .color(color)
    );

    always #5 clk = ~clk;

    assign pix_now = {6'd0, CounterX, 3'd0, CounterY, 1'b0, color};

    int n_checks = 0, n_errors = 0;
    int gx[N], gy[N], gw[N], gh[N], gc[N];
    int m_ptr = 0;
    bit m_last0 = 1'b0;
    pix_q_t obs_q;
    int last_count;
    int ready_mode = 0, stall_at = 0, stall_left = 0;
    int hold_x = -1, hold_cnt = 0;
    bit prev_stall = 1'b0;
    logic [31:0] prev_pix;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] pack(input int x, input int y, input int c);
        return 32'((x << 16) | (y << 4) | c);
    endfunction

    // Pixels a rectangle should produce: visible part only, row by row.
    function automatic pix_q_t exp_pixels(input int i);
        pix_q_t q;
        int xe, ye;
        xe = (gx[i] + gw[i] < SW) ? gx[i] + gw[i] : SW;
        ye = (gy[i] + gh[i] < SH) ? gy[i] + gh[i] : SH;
        for (int y = gy[i]; y < ye; y++)
            for (int x = gx[i]; x < xe; x++)
                q.push_back(pack(x, y, gc[i]));
        return q;
    endfunction

    function automatic int model_pick(input logic [N-1:0] pend);
`ifdef CLEAR_PRIORITY_EN
        if (pend[0] && !m_last0) return 0;
        for (int k = 0; k < N; k++)
            if ((m_ptr + k) % N != 0 && pend[(m_ptr + k) % N]) return (m_ptr + k) % N;
        if (pend[0]) return 0;
`else
        for (int k = 0; k < N; k++)
            if (pend[(m_ptr + k) % N]) return (m_ptr + k) % N;
`endif
        return -1;
    endfunction

    task automatic model_update(input int idx);
`ifdef CLEAR_PRIORITY_EN
        if (idx != 0) m_ptr = (idx + 1) % N;
        m_last0 = (idx == 0);
`else
        m_ptr = (idx + 1) % N;
`endif
    endtask

    function automatic int onehot_idx(input logic [N-1:0] v);
        int r = -1;
        for (int i = 0; i < N; i++) if (v[i]) r = i;
        return r;
    endfunction

    task automatic apply_geom();
        for (int i = 0; i < N; i++) begin
            rect_x[i*XW +: XW]   = XW'(gx[i]);
            rect_y[i*YW +: YW]   = YW'(gy[i]);
            rect_w[i*XW +: XW]   = XW'(gw[i]);
            rect_h[i*YW +: YW]   = YW'(gh[i]);
            rect_color[i*3 +: 3] = 3'(gc[i]);
        end
    endtask

    task automatic check_pixels(input int idx);
        pix_q_t ep;
        ep = exp_pixels(idx);
        last_count = obs_q.size();
        chk("pix_count", obs_q.size(), ep.size());
        for (int j = 0; j < ep.size() && j < obs_q.size(); j++) chk("pixel", obs_q[j], ep[j]);
        obs_q.delete();
    endtask

    task automatic wait_idle();
        for (int c = 0; c < 10 && busy; c++) @(negedge clk);
        chk("idle", busy, 1'b0);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        req = '0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        m_ptr = 0;
        m_last0 = 1'b0;
        obs_q.delete();
        @(negedge clk);
    endtask

    // Requesters in mask are held until their own done; order and pixels follow the model.
    task automatic serve(input logic [N-1:0] mask, input int max_cycles);
        logic [N-1:0] pend;
        int cyc, got_idx, exp_idx;
        pend = mask;
        cyc = 0;
        obs_q.delete();
        req = mask;
        while (pend != '0 && cyc < max_cycles) begin
            @(negedge clk);
            cyc++;
            if (done != '0) begin
                got_idx = onehot_idx(done);
                exp_idx = model_pick(pend);
                chk("done_onehot", $countones(done), 1);
                chk("done_idx", got_idx, exp_idx);
                check_pixels(exp_idx);
                if (got_idx < 0) got_idx = exp_idx;
                model_update(got_idx);
                pend[got_idx] = 1'b0;
                req[got_idx] = 1'b0;
            end
        end
        if (pend != '0) chk("serve_timeout", pend, '0);
        req = '0;
        wait_idle();
    endtask

    task automatic order_test(input logic [N-1:0] mask, input int n, input int e0, input int e1,
                              input int e2, input int e3);
        int exp_o[4];
        int got_n, cyc, idx;
        exp_o = '{e0, e1, e2, e3};
        got_n = 0;
        cyc = 0;
        obs_q.delete();
        req = mask;
        while (got_n < n && cyc < 500) begin
            @(negedge clk);
            cyc++;
            if (done != '0) begin
                idx = onehot_idx(done);
                chk("order", idx, exp_o[got_n]);
                chk("order_model", idx, model_pick(mask));
                check_pixels(idx < 0 ? 0 : idx);
                model_update(idx < 0 ? 0 : idx);
                got_n++;
                if (got_n == n) req = '0;
            end
        end
        if (got_n < n) chk("order_timeout", got_n, n);
        req = '0;
        wait_idle();
    endtask

    task automatic zero_test(input int idx, input string tag);
        obs_q.delete();
        req = N'(1) << idx;
        @(negedge clk);
        chk({tag, "_grant"}, grant, N'(1) << idx);
        @(negedge clk);
        chk({tag, "_done"}, done, N'(1) << idx);
        req = '0;
        @(negedge clk);
        chk({tag, "_idle"}, busy, 1'b0);
        chk({tag, "_noplot"}, obs_q.size(), 0);
        model_update(idx);
    endtask

    // Pixel monitor: records transfers and checks outputs hold steady while stalled.
    initial forever begin
        @(negedge clk);
        if (rst === 1'b1) begin
            if (prev_stall) begin
                chk("stall_plot", plot, 1'b1);
                chk("stall_hold", pix_now, prev_pix);
            end
            if (plot && plot_ready) obs_q.push_back(pix_now);
            if (plot && int'(CounterX) == hold_x) hold_cnt++;
            prev_stall = plot && !plot_ready;
            prev_pix = pix_now;
        end else begin
            prev_stall = 1'b0;
        end
    end

    initial begin
        plot_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                1: plot_ready = 1'($urandom_range(0, 1));
                2: begin
                    if (plot && obs_q.size() == stall_at && stall_left > 0) begin
                        plot_ready = 1'b0;
                        stall_left--;
                    end else begin
                        plot_ready = 1'b1;
                    end
                end
                default: plot_ready = 1'b1;
            endcase
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [N-1:0] mask;
        int cyc;
        rst = 1'b0;
        req = '0;
        for (int i = 0; i < N; i++) begin gx[i] = 0; gy[i] = 0; gw[i] = 0; gh[i] = 0; gc[i] = 0; end
        apply_geom();
        repeat (3) @(negedge clk);
        chk("rst_grant", grant, '0);
        chk("rst_done", done, '0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_plot", plot, 1'b0);
        chk("rst_x", CounterX, '0);
        chk("rst_y", CounterY, '0);
        chk("rst_color", color, '0);
        rst = 1'b1;
        @(negedge clk);
        chk("post_rst_busy", busy, 1'b0);

        // Round robin with two held requesters
        gx[0] = 0;  gy[0] = 0;  gw[0] = 2; gh[0] = 1; gc[0] = 1;
        gx[1] = 50; gy[1] = 60; gw[1] = 2; gh[1] = 1; gc[1] = 3;
        gx[2] = 10; gy[2] = 10; gw[2] = 2; gh[2] = 1; gc[2] = 2;
        apply_geom();
        do_reset();
        order_test(4'b0101, 3, 0, 2, 0, 0);
        do_reset();
`ifdef CLEAR_PRIORITY_EN
        order_test(4'b0111, 4, 0, 1, 0, 2);
`else
        order_test(4'b0111, 4, 0, 1, 2, 0);
`endif

        // Single paddle, cycle-exact
        gx[1] = 5; gy[1] = 100; gw[1] = 1; gh[1] = 4; gc[1] = 7;
        apply_geom();
        obs_q.delete();
        req = 4'b0010;
        @(negedge clk);
        chk("p_grant", grant, 4'b0010);
        chk("p_busy", busy, 1'b1);
        chk("p_noplot", plot, 1'b0);
        for (int j = 0; j < 4; j++) begin
            @(negedge clk);
            chk("p_plot", plot, 1'b1);
            chk("p_pix", pix_now, pack(5, 100 + j, 7));
        end
        @(negedge clk);
        chk("p_done", done, 4'b0010);
        chk("p_plot_off", plot, 1'b0);
        chk("p_grant_off", grant, '0);
        req = '0;
        @(negedge clk);
        chk("p_busy_off", busy, 1'b0);
        chk("p_done_off", done, '0);
        model_update(1);
        obs_q.delete();

        // Clipping at the bottom-right corner
        gx[3] = 318; gy[3] = 239; gw[3] = 5; gh[3] = 3; gc[3] = 6;
        apply_geom();
        serve(4'b1000, 200);
        chk("clip_count", last_count, 2);

        // Off-screen and zero-size rectangles
        gx[2] = 400; gy[2] = 20; gw[2] = 4; gh[2] = 4; gc[2] = 1;
        gx[3] = 30;  gy[3] = 30; gw[3] = 0; gh[3] = 5; gc[3] = 2;
        apply_geom();
        zero_test(2, "offscreen");
        zero_test(3, "zero_w");

        // Backpressure on the second pixel
        gx[1] = 20; gy[1] = 50; gw[1] = 3; gh[1] = 1; gc[1] = 4;
        apply_geom();
        ready_mode = 2; stall_at = 1; stall_left = 3; hold_x = 21; hold_cnt = 0;
        serve(4'b0010, 200);
        chk("bp_hold", hold_cnt, 4);
        chk("bp_count", last_count, 3);
        ready_mode = 0; hold_x = -1;

        // Reset in the middle of a 20x20 box
        gx[2] = 0; gy[2] = 0; gw[2] = 20; gh[2] = 20; gc[2] = 5;
        apply_geom();
        obs_q.delete();
        req = 4'b0100;
        cyc = 0;
        while (obs_q.size() < 9 && cyc < 200) begin
            @(negedge clk);
            #1;
            cyc++;
        end
        chk("mid_reach", obs_q.size(), 9);
        rst = 1'b0;
        #1;
        chk("mid_plot", plot, 1'b0);
        chk("mid_grant", grant, '0);
        chk("mid_done", done, '0);
        chk("mid_busy", busy, 1'b0);
        chk("mid_x", CounterX, '0);
        chk("mid_y", CounterY, '0);
        chk("mid_color", color, '0);
        req = '0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        m_ptr = 0;
        m_last0 = 1'b0;
        obs_q.delete();
        @(negedge clk);
        chk("mid_idle", busy, 1'b0);
        gx[1] = 100; gy[1] = 100; gw[1] = 3; gh[1] = 2; gc[1] = 3;
        apply_geom();
        serve(4'b0010, 200);

        // Random requests, geometry and backpressure
        ready_mode = 1;
        for (int t = 0; t < 40; t++) begin
            for (int i = 0; i < N; i++) begin
                gx[i] = $urandom_range(0, 1) ? $urandom_range(0, 330) : $urandom_range(310, 325);
                gy[i] = $urandom_range(0, 1) ? $urandom_range(0, 250) : $urandom_range(232, 245);
                gw[i] = $urandom_range(0, 7);
                gh[i] = $urandom_range(0, 4);
                gc[i] = $urandom_range(0, 7);
            end
            apply_geom();
            @(negedge clk);
            mask = N'($urandom_range(1, (1 << N) - 1));
            serve(mask, 3000);
        end
        ready_mode = 0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
